ct_add_arb: RTL and testbench
=============================

Name: ct_add_arb

Overview:
- Shares one LANES-wide modular-add datapath between two ciphertext requesters, using round-robin arbitration.
- On acceptance, the block captures the granted requester's operand pair and sequences the slots through the lanes: polynomial A first, then polynomial B.
- The result is presented as a full CT_t with a valid/ready handshake.
- Sits between the scheduler-side requesters (e.g. relinearize/rescale pipelines) and downstream ciphertext storage; replaces per-requester full-width adders.

Parameters:
- N, N_SLOTS_L, slots per polynomial.
- W, W_BITS_L, bits per coefficient word.
- QP, Q_MOD_L, modulus q; operands are required to be < QP.
- LANES, 4, coefficient adds per cycle; N % LANES == 0 and LANES >= 1 (elaboration-time check).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  [1:0]  requester i has an operand pair ready.
- req_ready  output  [1:0]  one-hot grant; acceptance when req_valid[i] & req_ready[i].
- req_ct1  input  CT_t[1:0]  first operand per requester; must be stable while req_valid[i] is high.
- req_ct2  input  CT_t[1:0]  second operand per requester; same stability rule.
- out_valid  output  1  out_ct/out_id hold a completed sum.
- out_ready  input  1  consumer accepts the result.
- out_ct  output  CT_t  result: A[i] = (ct1.A[i]+ct2.A[i]) mod QP; B likewise.
- out_id  output  1  index of the requester that produced out_ct.
- busy  output  1  high in RUN_A, RUN_B and DONE.

Behaviour:
- States: IDLE, RUN_A, RUN_B, DONE. On reset:
  - state=IDLE, beat counter=0, last_grant=1 (so requester 0 wins the first tie).
  - out_valid=0, out_ct=0, out_id=0, req_ready=0, busy=0.
- IDLE:
  - req_ready is combinational and non-zero only in IDLE.
  - If exactly one req_valid is set, grant it.
  - If both are set, grant ~last_grant.
  - On acceptance: latch req_ct1/req_ct2 of the winner into internal operand registers, record out_id, update last_grant, clear counter, go to RUN_A.
  - The requester is free to change its inputs the cycle after acceptance.
- RUN_A:
  - Each cycle, lanes k=0..LANES-1 compute slot j=cnt*LANES+k.
  - sum = {1'b0,a}+{1'b0,b} in W+1 bits; the result is sum-QP if sum>=QP, else sum; the low W bits are written to out_ct.A[j].
  - cnt increments. When cnt reaches N/LANES-1, cnt wraps to 0 and the state goes to RUN_B.
- RUN_B: identical, writing out_ct.B[j]; after the last beat, go to DONE.
- DONE:
  - out_valid=1; out_ct and out_id are held stable.
  - When out_ready=1, out_valid drops next cycle and the state returns to IDLE.
  - No request is accepted in the same cycle as the output handshake.
- Latency: acceptance at cycle t; beats at t+1..t+2N/LANES; out_valid first high at t+2N/LANES+1.
- Throughput: one ciphertext per 2N/LANES+2 cycles with out_ready tied high.
- Stale slots: out_ct slots not yet overwritten hold their previous values during RUN states; this is not observable, because out_valid=0.
- Backpressure: out_ready low in DONE holds indefinitely; new req_valid is ignored (req_ready=0).
- Fairness: last_grant updates only on acceptance. A requester that drops req_valid before grant loses nothing.
- Reset mid-operation: any state returns to IDLE next edge with all outputs at reset values; the partial result is discarded.
- Boundary: a+b=2QP-2 (max legal) gives QP-2; a+b=QP gives 0; W+1-bit sum never overflows.

Test Plan:
Bench parameters for all scenarios: N=8, W=5, QP=17, LANES=2.
1. Single request: req0 only, ct1.A=ct1.B=all 16, ct2.A=ct2.B=all 16 -> out_valid at acceptance+9; all A[i]=B[i]=15; out_id=0.
2. Exact-modulus and wrap boundaries: ct1.A[i]=i, ct2.A[i]=17-i (i=1..7), ct2.A[0]=0; B pairs (8,8) -> A[0]=0, A[1..7]=0; B[i]=16.
3. Arbitration: both req_valid held high for 3 consecutive jobs from reset -> grant order 0,1,0; each out_id matches; req_ready never two-hot.
4. Backpressure: out_ready low 5 cycles in DONE -> out_valid/out_ct stable, req_ready=0 throughout; one cycle after out_ready=1, req_ready is asserted for the pending requester.
5. Reset mid-run: assert rst during RUN_B beat 2 -> next cycle state IDLE, out_valid=0, out_ct=0, busy=0. A fresh request after reset is granted to req0 on a tie and completes correctly.
6. Operand release: change req_ct1 to garbage the cycle after acceptance -> output equals the sum of the originally latched operands.

Source files
------------

// File: rtl/ct_add_arb_if.sv
// Request/result bundle for ct_add_arb. Each ciphertext is flattened as
// {B[N-1..0], A[N-1..0]}, with W bits per coefficient and slot 0 in the LSBs.
interface ct_add_arb_if #(
  parameter int N = 8,
  parameter int W = 5
);
  localparam int CTW = 2 * N * W;

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][CTW-1:0]  req_ct1;
  logic [1:0][CTW-1:0]  req_ct2;
  logic                 out_valid;
  logic                 out_ready;
  logic [CTW-1:0]       out_ct;
  logic                 out_id;

  modport master (
    output req_valid, req_ct1, req_ct2, out_ready,
    input  req_ready, out_valid, out_ct, out_id
  );

  modport slave (
    input  req_valid, req_ct1, req_ct2, out_ready,
    output req_ready, out_valid, out_ct, out_id
  );
endinterface

// File: rtl/ct_add_arb.sv
// Round-robin shared modular adder for two ciphertext requesters. Each job is
// LANES coefficients per beat, polynomial A first and then polynomial B.
module ct_add_arb #(
  parameter int N     = 8,
  parameter int W     = 5,
  parameter int QP    = 17,
  parameter int LANES = 4
) (
  input  logic          clk,
  input  logic          rst,
  ct_add_arb_if.slave   bus,
  output logic          busy
);
  localparam int CTW   = 2 * N * W;
  localparam int BEATS = (LANES > 0) ? (N / LANES) : 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [W:0] QPW = (W+1)'(QP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN_A = 2'd1;
  localparam logic [1:0] S_RUN_B = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if ((LANES < 1) || ((N % LANES) != 0)) begin : g_cfg_err
    $error("ct_add_arb: LANES must be >= 1 and divide N");
  end

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_last_grant;
  logic [CTW-1:0] r_op1;
  logic [CTW-1:0] r_op2;
  logic [CTW-1:0] r_out_ct;
  logic           r_out_id;

  logic [1:0]     w_grant;
  logic           w_accept;
  logic           w_win;
  int             w_base;
  logic [W:0]     w_sum [LANES];
  logic [W-1:0]   w_res [LANES];

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == S_IDLE) begin
      case (bus.req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_accept      = |w_grant;
  assign w_win         = w_grant[1];
  assign bus.req_ready = w_grant;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_ct    = r_out_ct;
  assign bus.out_id    = r_out_id;
  assign busy          = (r_state != S_IDLE);

  // Operands are below QP, so one conditional subtract completes the reduction.
  always_comb begin
    w_base = ((r_state == S_RUN_B) ? N : 0) + int'(r_cnt) * LANES;
    for (int k = 0; k < LANES; k++) begin
      w_sum[k] = {1'b0, r_op1[(w_base + k) * W +: W]} + {1'b0, r_op2[(w_base + k) * W +: W]};
      w_res[k] = (w_sum[k] >= QPW) ? W'(w_sum[k] - QPW) : w_sum[k][W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_op1        <= '0;
      r_op2        <= '0;
      r_out_ct     <= '0;
      r_out_id     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op1        <= bus.req_ct1[w_win];
            r_op2        <= bus.req_ct2[w_win];
            r_out_id     <= w_win;
            r_last_grant <= w_win;
            r_cnt        <= '0;
            r_state      <= S_RUN_A;
          end
        end
        S_RUN_A, S_RUN_B: begin
          for (int k = 0; k < LANES; k++) begin
            r_out_ct[(w_base + k) * W +: W] <= w_res[k];
          end
          if (r_cnt == CW'(BEATS - 1)) begin
            r_cnt   <= '0;
            r_state <= (r_state == S_RUN_A) ? S_RUN_B : S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ct_add_arb.sv
// Scoreboard bench for ct_add_arb: expected sums are queued on each acceptance
// and compared when the result handshake completes.
module tb_ct_add_arb;
  localparam int N     = 8;
  localparam int W     = 5;
  localparam int QP    = 17;
  localparam int LANES = 2;
  localparam int CTW   = 2 * N * W;

  typedef struct packed {
    logic           id;
    logic [CTW-1:0] ct;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  ct_add_arb_if #(.N(N), .W(W)) bus ();

  ct_add_arb #(.N(N), .W(W), .QP(QP), .LANES(LANES)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CTW-1:0] fill(input int v);
    logic [CTW-1:0] r;
    r = '0;
    for (int j = 0; j < 2 * N; j++) r[j*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [CTW-1:0] model_add(input logic [CTW-1:0] a, input logic [CTW-1:0] b);
    logic [CTW-1:0] r;
    int s;
    r = '0;
    for (int j = 0; j < 2 * N; j++) begin
      s = int'(a[j*W +: W]) + int'(b[j*W +: W]);
      if (s >= QP) s = s - QP;
      r[j*W +: W] = W'(s);
    end
    return r;
  endfunction

  function automatic logic [CTW-1:0] rand_ct();
    logic [CTW-1:0] r;
    r = '0;
    for (int j = 0; j < 2 * N; j++) r[j*W +: W] = W'($urandom_range(0, QP - 1));
    return r;
  endfunction

  // Expected results are computed from the operands the DUT sees at the accepting edge.
  always @(posedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          e.id = 1'(i);
          e.ct = model_add(bus.req_ct1[i], bus.req_ct2[i]);
          sb.push_back(e);
        end
      end
    end
  end

  task automatic wait_accept(output int n);
    n = 0;
    #1;
    while (!(|(bus.req_valid & bus.req_ready)) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) n = -1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (bus.out_ct !== '0) begin n_errors++; $display("[TB] FAIL reset_out_ct: got %h expected 0", bus.out_ct); end
    n_checks++;
    if (bus.out_id !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_out_id: got %b expected 0", bus.out_id); end
    n_checks++;
    if (bus.req_ready !== 2'b00) begin n_errors++; $display("[TB] FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    int n;
    exp_t e;
    bus.req_ct1[0]  = fill(16);
    bus.req_ct2[0]  = fill(16);
    bus.out_ready   = 1'b1;
    bus.req_valid   = 2'b01;
    wait_accept(n);
    n_checks++;
    if (n != 0) begin n_errors++; $display("[TB] FAIL single_accept: got wait %0d expected 0", n); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_out(n);
    n_checks++;
    if (n + 1 != 2 * N / LANES + 1) begin n_errors++; $display("[TB] FAIL single_latency: got %0d expected %0d", n + 1, 2 * N / LANES + 1); end
    n_checks++;
    if (bus.out_ct !== fill(15)) begin n_errors++; $display("[TB] FAIL single_ct: got %h expected %h", bus.out_ct, fill(15)); end
    n_checks++;
    if (sb.size() == 0) begin n_errors++; $display("[TB] FAIL single_sb: got empty scoreboard expected 1 entry"); end
    else begin
      e = sb.pop_front();
      if (bus.out_id !== 1'b0 || e.id !== 1'b0) begin n_errors++; $display("[TB] FAIL single_id: got %b/%b expected 0", bus.out_id, e.id); end
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL single_valid_drop: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_boundary;
    int n;
    exp_t e;
    logic [CTW-1:0] a, b, want;
    a = '0;
    b = '0;
    want = '0;
    for (int i = 0; i < N; i++) begin
      a[i*W +: W] = W'(i);
      b[i*W +: W] = (i == 0) ? W'(0) : W'(17 - i);
      a[(N+i)*W +: W] = W'(8);
      b[(N+i)*W +: W] = W'(8);
      want[(N+i)*W +: W] = W'(16);
    end
    bus.req_ct1[0] = a;
    bus.req_ct2[0] = b;
    bus.req_valid  = 2'b01;
    wait_accept(n);
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_out(n);
    n_checks++;
    if (bus.out_ct !== want) begin n_errors++; $display("[TB] FAIL boundary_ct: got %h expected %h", bus.out_ct, want); end
    n_checks++;
    if (sb.size() == 0) begin n_errors++; $display("[TB] FAIL boundary_sb: got empty scoreboard expected 1 entry"); end
    else begin
      e = sb.pop_front();
      if (bus.out_ct !== e.ct) begin n_errors++; $display("[TB] FAIL boundary_sb_ct: got %h expected %h", bus.out_ct, e.ct); end
    end
    @(negedge clk);
  endtask

  task automatic test_arbitration;
    int n;
    bit two_hot;
    exp_t e;
    logic order [3];
    order[0] = 1'b0;
    order[1] = 1'b1;
    order[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    bus.req_ct1[0] = fill(3);
    bus.req_ct2[0] = fill(5);
    bus.req_ct1[1] = fill(12);
    bus.req_ct2[1] = fill(9);
    bus.out_ready  = 1'b1;
    bus.req_valid  = 2'b11;
    for (int j = 0; j < 3; j++) begin
      two_hot = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 100) begin
        #1;
        if (bus.req_ready == 2'b11) two_hot = 1'b1;
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (two_hot) begin n_errors++; $display("[TB] FAIL arb_one_hot_%0d: got 11 expected one-hot", j); end
      n_checks++;
      if (bus.out_id !== order[j]) begin n_errors++; $display("[TB] FAIL arb_order_%0d: got %b expected %b", j, bus.out_id, order[j]); end
      n_checks++;
      if (sb.size() == 0) begin n_errors++; $display("[TB] FAIL arb_sb_%0d: got empty scoreboard expected 1 entry", j); end
      else begin
        e = sb.pop_front();
        if (bus.out_ct !== e.ct || bus.out_id !== e.id) begin
          n_errors++; $display("[TB] FAIL arb_ct_%0d: got %h/%b expected %h/%b", j, bus.out_ct, bus.out_id, e.ct, e.id);
        end
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int n;
    exp_t e;
    logic [CTW-1:0] held;
    bus.req_ct1[0] = rand_ct();
    bus.req_ct2[0] = rand_ct();
    bus.out_ready  = 1'b0;
    bus.req_valid  = 2'b01;
    wait_accept(n);
    @(negedge clk);
    bus.req_ct1[1] = rand_ct();
    bus.req_ct2[1] = rand_ct();
    bus.req_valid  = 2'b10;
    wait_out(n);
    held = bus.out_ct;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ct !== held || bus.req_ready !== 2'b00) begin
        n_errors++; $display("[TB] FAIL bp_hold_%0d: got valid %b ready %b ct %h expected 1 00 %h", c, bus.out_valid, bus.req_ready, bus.out_ct, held);
      end
    end
    n_checks++;
    if (sb.size() == 0) begin n_errors++; $display("[TB] FAIL bp_sb: got empty scoreboard expected entry"); end
    else begin
      e = sb.pop_front();
      if (bus.out_ct !== e.ct || bus.out_id !== e.id) begin n_errors++; $display("[TB] FAIL bp_ct: got %h/%b expected %h/%b", bus.out_ct, bus.out_id, e.ct, e.id); end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b10 || bus.out_valid !== 1'b0) begin
      n_errors++; $display("[TB] FAIL bp_release: got ready %b valid %b expected 10 0", bus.req_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_out(n);
    n_checks++;
    if (sb.size() == 0) begin n_errors++; $display("[TB] FAIL bp_pending_sb: got empty scoreboard expected entry"); end
    else begin
      e = sb.pop_front();
      if (bus.out_ct !== e.ct || bus.out_id !== 1'b1) begin n_errors++; $display("[TB] FAIL bp_pending_ct: got %h/%b expected %h/1", bus.out_ct, bus.out_id, e.ct); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    exp_t e;
    bus.req_ct1[0] = rand_ct();
    bus.req_ct2[0] = rand_ct();
    bus.req_valid  = 2'b01;
    wait_accept(n);
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (2 * N / LANES - 2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_ct !== '0 || bus.out_id !== 1'b0 || bus.req_ready !== 2'b00) begin
      n_errors++; $display("[TB] FAIL mid_reset: got valid %b busy %b id %b ready %b ct %h expected all 0",
                           bus.out_valid, busy, bus.out_id, bus.req_ready, bus.out_ct);
    end
    rst = 1'b0;
    sb.delete();
    bus.req_ct1[0] = fill(10);
    bus.req_ct2[0] = fill(11);
    bus.req_ct1[1] = fill(1);
    bus.req_ct2[1] = fill(2);
    bus.req_valid  = 2'b11;
    wait_accept(n);
    n_checks++;
    if (bus.req_ready !== 2'b01) begin n_errors++; $display("[TB] FAIL mid_tie_grant: got %b expected 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_out(n);
    n_checks++;
    if (bus.out_ct !== fill(4) || bus.out_id !== 1'b0) begin n_errors++; $display("[TB] FAIL mid_fresh: got %h/%b expected %h/0", bus.out_ct, bus.out_id, fill(4)); end
    if (sb.size() != 0) e = sb.pop_front();
    @(negedge clk);
  endtask

  task automatic test_release;
    int n;
    exp_t e;
    bus.req_ct1[1] = rand_ct();
    bus.req_ct2[1] = rand_ct();
    bus.req_valid  = 2'b10;
    wait_accept(n);
    @(negedge clk);
    bus.req_valid  = 2'b00;
    bus.req_ct1[1] = {$urandom, $urandom, $urandom};
    bus.req_ct2[1] = {$urandom, $urandom, $urandom};
    wait_out(n);
    n_checks++;
    if (sb.size() == 0) begin n_errors++; $display("[TB] FAIL release_sb: got empty scoreboard expected entry"); end
    else begin
      e = sb.pop_front();
      if (bus.out_ct !== e.ct || bus.out_id !== 1'b1) begin n_errors++; $display("[TB] FAIL release_ct: got %h/%b expected %h/1", bus.out_ct, bus.out_id, e.ct); end
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_ct1    = '0;
    bus.req_ct2    = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_single();
    test_boundary();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_release();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
